// File: rtl/menu_pkg.sv
// Shared definitions for the menu controller.
//   menu_state_t : menu button FSM encoding
//   MAX_SCREEN   : highest valid screen index
//   SCREEN_W     : width of a screen index
//   cnt_width()  : bit width needed to hold a counter value
//   max_u()      : larger of two unsigned values
package menu_pkg;

    localparam int unsigned MAX_SCREEN = 10;
    localparam int unsigned SCREEN_W   = 4;

    typedef enum logic [1:0] {
        M_IDLE     = 2'd0,
        M_PRESS    = 2'd1,
        M_LONG     = 2'd2,
        M_WAIT_REL = 2'd3
    } menu_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Always at least one bit so a zero-valued parameter still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce filter for one raw push-button.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   raw        : asynchronous button input
//   level      : debounced level
//   rise, fall : one-cycle pulses, registered together with the level change
module btn_debounce
    import menu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned DB_EFF = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
    localparam int unsigned CW     = cnt_width(DB_EFF);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_EFF - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == level) begin
                // Any bounce back to the current level restarts the stability window.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/menu_ctrl.sv
// Button front end and screen selector for the menu system.
// Ports:
//   clk, reset                : system clock, asynchronous active-high reset
//   btn_menu, btn_up, btn_down: raw active-high push-buttons
//   goto_valid, goto_screen   : one-cycle screen-change request from the active screen
//   select                    : current screen index (downstream dmux select)
//   wrmenu, up, down          : one-cycle, mutually exclusive event pulses
// A short menu press emits wrmenu on release; a long press returns to screen 0
// silently. Up/down emit a pulse per press and auto-repeat while held.
module menu_ctrl
    import menu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_menu,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                goto_valid,
    input  logic [SCREEN_W-1:0] goto_screen,
    output logic [SCREEN_W-1:0] select,
    output logic                wrmenu,
    output logic                up,
    output logic                down
);

    localparam int unsigned HOLD_MAX = max_u(LONG_CYCLES, REPEAT_DELAY + REPEAT_PERIOD);
    localparam int unsigned HW       = cnt_width(HOLD_MAX);

    localparam logic [HW-1:0] LONG_C     = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] REP_FIRST  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] REP_WRAP   = HW'(REPEAT_DELAY + REPEAT_PERIOD);
    localparam logic [HW-1:0] REP_RELOAD = HW'(REPEAT_DELAY + 1);
    localparam logic [HW-1:0] HOLD_SAT   = HW'(HOLD_MAX);

    localparam logic [SCREEN_W-1:0] SCREEN_MAX = SCREEN_W'(MAX_SCREEN);

    // ------------------------------------------------------------------
    // Debounced buttons
    // ------------------------------------------------------------------
    logic m_level, m_rise, m_fall;
    logic u_level, u_rise, u_fall;
    logic d_level, d_rise, d_fall;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_menu (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_menu),
        .level (m_level),
        .rise  (m_rise),
        .fall  (m_fall)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_up),
        .level (u_level),
        .rise  (u_rise),
        .fall  (u_fall)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_down),
        .level (d_level),
        .rise  (d_rise),
        .fall  (d_fall)
    );

    // Repeat counters clear on the debounced level, so the fall pulses are not needed.
    logic unused_falls;
    assign unused_falls = u_fall ^ d_fall;

    // ------------------------------------------------------------------
    // Menu button FSM
    // ------------------------------------------------------------------
    menu_state_t   state;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= M_IDLE;
            hold_cnt <= '0;
        end else begin
            unique case (state)
                M_IDLE: begin
                    if (m_rise) begin
                        state    <= M_PRESS;
                        hold_cnt <= '0;
                    end
                end
                M_PRESS: begin
                    if (m_fall) begin
                        state <= M_IDLE;
                    end else if (hold_cnt >= LONG_C) begin
                        state <= M_LONG;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                M_LONG: begin
                    state <= M_WAIT_REL;
                end
                M_WAIT_REL: begin
                    // Level rather than fall: a release during M_LONG must not strand us here.
                    if (!m_level) begin
                        state <= M_IDLE;
                    end
                end
                default: state <= M_IDLE;
            endcase
        end
    end

    logic menu_evt;
    logic long_ret;

    assign menu_evt = (state == M_PRESS) && m_fall && (hold_cnt < LONG_C);
    assign long_ret = (state == M_LONG);

    // ------------------------------------------------------------------
    // Up/down auto-repeat
    // ------------------------------------------------------------------
    // Counter reads 1 in the cycle after the debounced edge, then counts held cycles.
    // A pulse fires at REPEAT_DELAY and every REPEAT_PERIOD after, by folding the
    // count from DELAY+PERIOD back to DELAY+1.
    function automatic logic [HW-1:0] rep_next(input logic [HW-1:0] cnt,
                                               input logic          lvl,
                                               input logic          edge_in);
        if (!lvl) begin
            return '0;
        end else if (edge_in) begin
            return HW'(1);
        end else if (cnt == REP_WRAP) begin
            return REP_RELOAD;
        end else if (cnt == HOLD_SAT) begin
            return cnt;
        end
        return cnt + HW'(1);
    endfunction

    logic [HW-1:0] up_cnt;
    logic [HW-1:0] down_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_cnt   <= '0;
            down_cnt <= '0;
        end else begin
            up_cnt   <= rep_next(up_cnt, u_level, u_rise);
            down_cnt <= rep_next(down_cnt, d_level, d_rise);
        end
    end

    logic up_evt;
    logic down_evt;

    assign up_evt   = u_rise || (u_level && !u_rise &&
                                 (up_cnt == REP_FIRST || up_cnt == REP_WRAP));
    assign down_evt = d_rise || (d_level && !d_rise &&
                                 (down_cnt == REP_FIRST || down_cnt == REP_WRAP));

    // ------------------------------------------------------------------
    // Screen select and output pulses
    // ------------------------------------------------------------------
    logic [SCREEN_W-1:0] sel_d;
    logic                blank;

    always_comb begin
        sel_d = select;
        if (long_ret) begin
            sel_d = '0;
        end else if (goto_valid && (goto_screen <= SCREEN_MAX)) begin
            sel_d = goto_screen;
        end
    end

    // blank is high for the first cycle a new select is presented; events
    // arising then are dropped so they cannot reach the wrong screen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            select <= '0;
            blank  <= 1'b0;
            wrmenu <= 1'b0;
            up     <= 1'b0;
            down   <= 1'b0;
        end else begin
            select <= sel_d;
            blank  <= (sel_d != select);
            wrmenu <= !blank && menu_evt;
            up     <= !blank && !menu_evt && up_evt;
            down   <= !blank && !menu_evt && !up_evt && down_evt;
        end
    end

endmodule

// File: tb/tb_menu_ctrl.sv
// Scoreboard bench for menu_ctrl: stimulus pushes expected pulses (kind, cycle)
// into a queue; a monitor pops and compares every pulse the DUT emits.
module tb_menu_ctrl;

    localparam int unsigned DB  = 4;
    localparam int unsigned LNG = 16;
    localparam int unsigned RD  = 20;
    localparam int unsigned RP  = 8;
    // Raw change driven at a negedge -> pulse: 2 sync flops + DB stable cycles + 1 output reg.
    localparam int unsigned LAT = DB + 3;

    localparam logic [2:0] K_MENU = 3'b100;
    localparam logic [2:0] K_UP   = 3'b010;
    localparam logic [2:0] K_DOWN = 3'b001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_menu = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       goto_valid = 1'b0;
    logic [3:0] goto_screen = 4'd0;
    logic [3:0] select;
    logic       wrmenu;
    logic       up;
    logic       down;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [2:0]  kind;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    menu_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LNG),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_menu    (btn_menu),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .goto_valid  (goto_valid),
        .goto_screen (goto_screen),
        .select      (select),
        .wrmenu      (wrmenu),
        .up          (up),
        .down        (down)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [2:0] kind, input int unsigned at);
        sb.push_back('{kind: kind, at: at});
    endtask

    task automatic drain(input string name);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every cycle with a pulse must match the head of the scoreboard.
    initial forever begin
        @(posedge clk);
        #1;
        if ({wrmenu, up, down} != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected pulse kind", 32'({wrmenu, up, down}), 0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse kind", 32'({wrmenu, up, down}), 32'(mon_e.kind));
                check("pulse cycle", cyc, mon_e.at);
            end
        end
    end

    int unsigned k;
    int unsigned rep_offs[6] = '{7, 27, 35, 43, 51, 59};
    logic [3:0]  bad_screens[3] = '{4'd11, 4'd12, 4'd15};

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #1;
        check("reset select", select, 0);
        check("reset wrmenu", wrmenu, 0);
        check("reset up", up, 0);
        check("reset down", down, 0);
        tick(2);
        reset = 1'b0;
        tick(3);

        // goto: valid screen taken next edge, out-of-range ignored
        goto_valid = 1'b1;
        goto_screen = 4'd9;
        tick(1);
        goto_valid = 1'b0;
        check("goto 9", select, 9);
        tick(1);
        check("goto 9 held", select, 9);
        for (int i = 0; i < 3; i++) begin
            goto_valid = 1'b1;
            goto_screen = bad_screens[i];
            tick(1);
            goto_valid = 1'b0;
            check("goto out of range ignored", select, 9);
        end
        tick(4);
        drain("goto no pulses");

        // Short menu press: wrmenu after debounced release, select unchanged
        btn_menu = 1'b1;
        tick(10);
        btn_menu = 1'b0;
        expect_pulse(K_MENU, cyc + LAT);
        tick(20);
        check("short press select", select, 9);
        drain("short press pulses");

        // Long menu press from screen 7: back to 0, no wrmenu
        goto_valid = 1'b1;
        goto_screen = 4'd7;
        tick(1);
        goto_valid = 1'b0;
        check("goto 7", select, 7);
        btn_menu = 1'b1;
        tick(30);
        check("long press select", select, 0);
        tick(10);
        btn_menu = 1'b0;
        tick(20);
        check("long press after release", select, 0);
        drain("long press pulses");

        // Bounce on btn_up, then stable high: a single up pulse
        for (int i = 0; i < 10; i++) begin
            btn_up = (i % 2 == 0);
            tick(2);
        end
        btn_up = 1'b1;
        expect_pulse(K_UP, cyc + LAT);
        tick(12);
        btn_up = 1'b0;
        tick(15);
        drain("bounce pulses");

        // Auto-repeat: btn_down held 60 cycles
        k = cyc;
        btn_down = 1'b1;
        for (int i = 0; i < 6; i++) expect_pulse(K_DOWN, k + rep_offs[i]);
        tick(60);
        btn_down = 1'b0;
        tick(20);
        drain("repeat pulses");

        // Priority: up and down debounce in the same cycle, only up pulses
        btn_up = 1'b1;
        btn_down = 1'b1;
        expect_pulse(K_UP, cyc + LAT);
        tick(10);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(15);
        drain("priority pulses");

        // Blanking: select changes one cycle before the up pulse would appear
        btn_up = 1'b1;
        tick(LAT - 2);
        goto_valid = 1'b1;
        goto_screen = 4'd5;
        tick(1);
        goto_valid = 1'b0;
        check("goto 5", select, 5);
        tick(5);
        btn_up = 1'b0;
        tick(15);
        check("blank select", select, 5);
        drain("blanked pulse dropped");

        // Reset mid-repeat, button held through reset release
        k = cyc;
        btn_down = 1'b1;
        expect_pulse(K_DOWN, k + LAT);
        expect_pulse(K_DOWN, k + LAT + RD);
        tick(LAT + RD - 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid reset select", select, 0);
        check("mid reset wrmenu", wrmenu, 0);
        check("mid reset up", up, 0);
        check("mid reset down", down, 0);
        tick(2);
        reset = 1'b0;
        expect_pulse(K_DOWN, cyc + LAT);
        tick(10);
        btn_down = 1'b0;
        tick(15);
        check("post reset select", select, 0);
        drain("reset pulses");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
